// File: rtl/ula_multiciclo_if.sv
// Request/result bundle between the register file side and the multi-cycle ALU.
// Flag signals exist only when ULA_FLAGS_EN is defined.
interface ula_multiciclo_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] saidaULA;
  logic [WIDTH-1:0] saidaAlta;
  logic             erro;
`ifdef ULA_FLAGS_EN
  logic             zero;
  logic             negativo;
  logic             carry;
  logic             overflow;
`endif

  modport master (
    output enable, opcode, regA, regB,
`ifdef ULA_FLAGS_EN
    input  zero, negativo, carry, overflow,
`endif
    input  busy, done, saidaULA, saidaAlta, erro
  );

  modport slave (
    input  enable, opcode, regA, regB,
`ifdef ULA_FLAGS_EN
    output zero, negativo, carry, overflow,
`endif
    output busy, done, saidaULA, saidaAlta, erro
  );
endinterface

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith ops (latency 1), iterative MUL/DIV one bit per cycle
// (latency WIDTH); requests while busy are dropped. Optional flags via ULA_FLAGS_EN.
module ula_multiciclo #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  ula_multiciclo_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ZERO = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOTA = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_PASA = 4'b1010;
  localparam logic [3:0] OP_PASB = 4'b1011;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, op_b;
  logic             op_div;
  logic             busy_q, done_q, erro_q;
  logic [WIDTH-1:0] lo_q, hi_q;

  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_err, is_iter;
  logic             st_div;
  logic [WIDTH-1:0] st_hi, st_lo, st_b;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             q_bit;
  logic [WIDTH-1:0] nx_hi, nx_lo;

  always_comb begin
    sc_lo   = '0;
    sc_hi   = '0;
    sc_err  = 1'b0;
    is_iter = 1'b0;
    case (bus.opcode)
      OP_ZERO: sc_lo = '0;
      OP_ADD:  sc_lo = bus.regA + bus.regB;
      OP_SUB:  sc_lo = bus.regA - bus.regB;
      OP_MUL:  is_iter = 1'b1;
      OP_DIV: begin
        if (bus.regB == '0) begin
          sc_lo  = '1;
          sc_hi  = bus.regA;
          sc_err = 1'b1;
        end else begin
          is_iter = 1'b1;
        end
      end
      OP_AND:  sc_lo = bus.regA & bus.regB;
      OP_OR:   sc_lo = bus.regA | bus.regB;
      OP_NOTA: sc_lo = ~bus.regA;
      OP_XOR:  sc_lo = bus.regA ^ bus.regB;
      OP_XNOR: sc_lo = ~(bus.regA ^ bus.regB);
      OP_PASA: sc_lo = bus.regA;
      OP_PASB: sc_lo = bus.regB;
      default: sc_err = 1'b1;
    endcase
  end

  // The first iteration runs on the accept edge straight from the ports, so the
  // last one lands WIDTH-1 edges later and done shows in the WIDTH-th cycle.
  always_comb begin
    if (state == IDLE) begin
      st_div = (bus.opcode == OP_DIV);
      st_hi  = '0;
      st_lo  = bus.regA;
      st_b   = bus.regB;
    end else begin
      st_div = op_div;
      st_hi  = acc_hi;
      st_lo  = acc_lo;
      st_b   = op_b;
    end
    mul_sum = {1'b0, st_hi} + (st_lo[0] ? {1'b0, st_b} : '0);
    rem_sh  = {st_hi, st_lo[WIDTH-1]};
    q_bit   = (rem_sh >= {1'b0, st_b});
    if (st_div) begin
      nx_hi = q_bit ? (rem_sh[WIDTH-1:0] - st_b) : rem_sh[WIDTH-1:0];
      nx_lo = {st_lo[WIDTH-2:0], q_bit};
    end else begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], st_lo[WIDTH-1:1]};
    end
  end

`ifdef ULA_FLAGS_EN
  logic sc_c, sc_v;
  logic fl_zero, fl_neg, fl_carry, fl_ovf;

  always_comb begin
    sc_c = 1'b0;
    sc_v = 1'b0;
    if (bus.opcode == OP_ADD) begin
      sc_c = (sc_lo < bus.regA);
      sc_v = (bus.regA[WIDTH-1] == bus.regB[WIDTH-1]) && (sc_lo[WIDTH-1] != bus.regA[WIDTH-1]);
    end else if (bus.opcode == OP_SUB) begin
      sc_c = (bus.regA < bus.regB);
      sc_v = (bus.regA[WIDTH-1] != bus.regB[WIDTH-1]) && (sc_lo[WIDTH-1] != bus.regA[WIDTH-1]);
    end
  end

  assign bus.zero     = fl_zero;
  assign bus.negativo = fl_neg;
  assign bus.carry    = fl_carry;
  assign bus.overflow = fl_ovf;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_b   <= '0;
      op_div <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      erro_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
`ifdef ULA_FLAGS_EN
      fl_zero  <= 1'b0;
      fl_neg   <= 1'b0;
      fl_carry <= 1'b0;
      fl_ovf   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (is_iter) begin
              state  <= CALC;
              busy_q <= 1'b1;
              cnt    <= CNT_W'(1);
              acc_hi <= nx_hi;
              acc_lo <= nx_lo;
              op_b   <= bus.regB;
              op_div <= (bus.opcode == OP_DIV);
            end else begin
              done_q <= 1'b1;
              lo_q   <= sc_lo;
              hi_q   <= sc_hi;
              erro_q <= sc_err;
`ifdef ULA_FLAGS_EN
              fl_zero  <= (sc_lo == '0);
              fl_neg   <= sc_lo[WIDTH-1];
              fl_carry <= sc_c;
              fl_ovf   <= sc_v;
`endif
            end
          end
        end
        CALC: begin
          acc_hi <= nx_hi;
          acc_lo <= nx_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            lo_q   <= nx_lo;
            hi_q   <= nx_hi;
            erro_q <= 1'b0;
`ifdef ULA_FLAGS_EN
            fl_zero  <= (nx_lo == '0);
            fl_neg   <= nx_lo[WIDTH-1];
            fl_carry <= !op_div && (nx_hi != '0);
            fl_ovf   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.erro      = erro_q;
  assign bus.saidaULA  = lo_q;
  assign bus.saidaAlta = hi_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo (WIDTH=8): directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_ula_multiciclo;
  localparam int W = 8;

  typedef struct {
    int lo;
    int hi;
    int err;
    int zf;
    int nf;
    int cf;
    int vf;
    int due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t q[$];
  int   free_at  = 0;
  int   acc_edge = 0;
  int   last_lo  = 0;
  int   last_hi  = 0;
  int   last_err = 0;

  ula_multiciclo_if #(.WIDTH(W)) bus ();
  ula_multiciclo #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int s8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic ref_op(input int op, input int a, input int b, output exp_t e, output int lat);
    int r;
    e = '{default: 0};
    lat = 1;
    case (op)
      0: e.lo = 0;
      1: begin
        r = a + b; e.lo = r % 256; e.cf = (r >= 256) ? 1 : 0;
        r = s8(a) + s8(b); e.vf = (r > 127 || r < -128) ? 1 : 0;
      end
      2: begin
        r = a - b; e.lo = (r + 256) % 256; e.cf = (a < b) ? 1 : 0;
        r = s8(a) - s8(b); e.vf = (r > 127 || r < -128) ? 1 : 0;
      end
      3: begin
        r = a * b; e.lo = r % 256; e.hi = r / 256; e.cf = (e.hi != 0) ? 1 : 0; lat = W;
      end
      4: begin
        if (b == 0) begin e.lo = 255; e.hi = a; e.err = 1; end
        else begin e.lo = a / b; e.hi = a % b; lat = W; end
      end
      5:  e.lo = a & b;
      6:  e.lo = a | b;
      7:  e.lo = 255 - a;
      8:  e.lo = a ^ b;
      9:  e.lo = 255 - (a ^ b);
      10: e.lo = a;
      11: e.lo = b;
      default: e.err = 1;
    endcase
    e.zf = (e.lo == 0) ? 1 : 0;
    e.nf = (e.lo >= 128) ? 1 : 0;
  endtask

  // Drive one request at the current negedge+1 and record it if the model says it is accepted.
  task automatic drive(input int en, input int op, input int a, input int b);
    exp_t e;
    int lat;
    bus.enable = en[0];
    bus.opcode = op[3:0];
    bus.regA   = a[W-1:0];
    bus.regB   = b[W-1:0];
    if (en != 0 && cyc + 1 >= free_at) begin
      ref_op(op, a, b, e, lat);
      e.due    = cyc + lat;
      acc_edge = cyc + 1;
      free_at  = cyc + 1 + lat;
      q.push_back(e);
    end
  endtask

  task automatic issue(input int op, input int a, input int b);
    int n = 0;
    @(negedge clock); #1;
    while (cyc + 1 < free_at && n < 40) begin
      drive(0, 0, 0, 0);
      @(negedge clock); #1;
      n++;
    end
    drive(1, op, a, b);
  endtask

  task automatic do_reset(input int edges);
    @(negedge clock); #1;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    q.delete();
    free_at = 0; acc_edge = 0;
    last_lo = 0; last_hi = 0; last_err = 0;
    repeat (edges) @(negedge clock);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_erro", int'(bus.erro), 0);
    chk("reset_saidaULA", int'(bus.saidaULA), 0);
    chk("reset_saidaAlta", int'(bus.saidaAlta), 0);
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks latency, busy and output hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("busy", int'(bus.busy), (cyc >= acc_edge && cyc <= free_at - 2) ? 1 : 0);
        if (bus.done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("latency", cyc, e.due);
            chk("saidaULA", int'(bus.saidaULA), e.lo);
            chk("saidaAlta", int'(bus.saidaAlta), e.hi);
            chk("erro", int'(bus.erro), e.err);
`ifdef ULA_FLAGS_EN
            chk("zero", int'(bus.zero), e.zf);
            chk("negativo", int'(bus.negativo), e.nf);
            chk("carry", int'(bus.carry), e.cf);
            chk("overflow", int'(bus.overflow), e.vf);
`endif
            last_lo = e.lo; last_hi = e.hi; last_err = e.err;
          end
        end else begin
          chk("hold", (int'(bus.saidaULA) << 16) | (int'(bus.saidaAlta) << 1) | int'(bus.erro),
              (last_lo << 16) | (last_hi << 1) | last_err);
          if (q.size() != 0 && cyc > q[0].due) begin
            chk("done_timeout", cyc, q[0].due);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    int op;
    int b;
    drive(0, 0, 0, 0);
    do_reset(3);

    issue(1, 200, 100);
    issue(3, 255, 255);
    issue(4, 100, 7);
    issue(4, 100, 0);

    // Requests during an ongoing MUL must be dropped and must not disturb it.
    issue(3, 13, 11);
    @(negedge clock); #1; drive(0, 0, 0, 0);
    @(negedge clock); #1; drive(1, 1, 1, 1);
    @(negedge clock); #1; drive(1, 1, 99, 42);
    @(negedge clock); #1; drive(0, 0, 0, 0);

    issue(3, 77, 201);
    repeat (3) begin @(negedge clock); #1; drive(0, 0, 0, 0); end
    do_reset(1);
    issue(2, 5, 7);

    issue(12, 9, 9);
    issue(8, 8'hF0, 8'h3C);
    issue(15, 1, 2);
    issue(4, 255, 1);
    issue(4, 0, 255);
    issue(3, 0, 200);
    issue(1, 127, 1);
    issue(2, 128, 1);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clock); #1;
      op = $urandom_range(0, 15);
      if (i % 4 == 0) op = $urandom_range(3, 4);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      drive(($urandom_range(0, 3) != 0) ? 1 : 0, op, $urandom_range(0, 255), b);
    end

    n = 0;
    @(negedge clock); #1; drive(0, 0, 0, 0);
    while (q.size() != 0 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    chk("drain_pending", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
